time_set_controller: RTL and testbench

Button-driven front end that produces the time-set interface of the digital clock: setMin, setHrs, setAM, setPM and setTime. It debounces three push-buttons and runs an edit state machine over a shadow copy of the current time. On commit it emits a one-cycle setTime pulse. It sits between the board buttons and the clock core and shares that core's clk and its switch (12/24-hour) level.

---
 rtl/time_set_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_time_set_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - button debounce, auto-repeat and time-set edit FSM
//
// Purpose: debounces the mode/inc/dec push-buttons and edits a shadow copy of
// the clock time. Commit produces a one-cycle setTime pulse toward the clock core.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   btn_mode, btn_inc, btn_dec  raw asynchronous push-buttons
//   switch                      1 = 12-hour mode, 0 = 24-hour mode
//   cur_min, cur_hrs, cur_pm    current time from the clock core
//   setMin, setHrs, setAM, setPM  registered shadow time
//   setTime                     one-cycle commit pulse
//   editing, edit_field         edit status (field: 0 none, 1 hrs, 2 min, 3 AM/PM)
`timescale 1ns/1ps
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       switch,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hrs,
    input  logic       cur_pm,
    output logic [5:0] setMin,
    output logic [4:0] setHrs,
    output logic       setAM,
    output logic       setPM,
    output logic       setTime,
    output logic       editing,
    output logic [1:0] edit_field
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HRS  = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_AMPM = 3'd3,
        COMMIT    = 3'd4
    } state_t;

    // Button index: 0 = mode, 1 = inc, 2 = dec
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      lvl_q, lvl_d;
    logic [2:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    // Repeat index: 0 = inc, 1 = dec
    logic [RP_W-1:0] rep_cnt_q [2];
    logic [RP_W-1:0] rep_cnt_d [2];
    logic [1:0]      rep_arm_q, rep_arm_d;
    logic [1:0]      rep_ev_q, rep_ev_d;

    state_t          state_q, state_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hrs_q, hrs_d;
    logic            am_q, am_d;
    logic            pm_q, pm_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            sw_q;

    logic mode_ev, inc_ev, dec_ev, any_ev, step_inc, step_dec, sw_chg;
    logic [4:0] load_hrs, hrs_inc, hrs_dec;
    logic [5:0] load_min, min_inc, min_dec;
    logic       load_am, load_pm;

    assign raw = {btn_dec, btn_inc, btn_mode};

    // Debounce: level follows the synchronized input only after
    // DEBOUNCE_CYCLES consecutive differing samples; press fires on the rise.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lvl_d[i]    = lvl_q[i];
            press_d[i]  = 1'b0;
            db_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat only counts while the level is held and not releasing this
    // cycle, so a repeat never coincides with the release edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i] = '0;
            rep_arm_d[i] = 1'b0;
            rep_ev_d[i]  = 1'b0;
            if (lvl_q[i+1] && lvl_d[i+1]) begin
                rep_arm_d[i] = rep_arm_q[i];
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                if (!rep_arm_q[i] && (rep_cnt_q[i] + 1'b1) == RP_W'(REPEAT_DELAY)) begin
                    rep_ev_d[i]  = 1'b1;
                    rep_arm_d[i] = 1'b1;
                    rep_cnt_d[i] = '0;
                end else if (rep_arm_q[i] && (rep_cnt_q[i] + 1'b1) == RP_W'(REPEAT_RATE)) begin
                    rep_ev_d[i]  = 1'b1;
                    rep_cnt_d[i] = '0;
                end
            end
        end
    end

    assign mode_ev  = press_q[0];
    assign inc_ev   = press_q[1] | rep_ev_q[0];
    assign dec_ev   = press_q[2] | rep_ev_q[1];
    assign any_ev   = mode_ev | inc_ev | dec_ev;
    assign step_inc = inc_ev & ~dec_ev & ~mode_ev;
    assign step_dec = dec_ev & ~inc_ev & ~mode_ev;
    assign sw_chg   = switch ^ sw_q;

    // Shadow load with 12/24-hour conversion and range clamping
    always_comb begin
        load_min = (cur_min > 6'd59) ? 6'd0 : cur_min;
        load_hrs = cur_hrs;
        load_am  = 1'b0;
        load_pm  = 1'b0;
        if (switch) begin
            if (cur_hrs == 5'd0) begin
                load_hrs = 5'd12;
                load_am  = 1'b1;
            end else if (cur_hrs > 5'd12) begin
                load_hrs = cur_hrs - 5'd12;
                load_pm  = 1'b1;
            end else begin
                load_am  = ~cur_pm;
                load_pm  = cur_pm;
            end
        end else if (cur_hrs > 5'd23) begin
            load_hrs = 5'd0;
        end
    end

    // Wrapping field arithmetic; minutes never carry into hours
    always_comb begin
        if (switch) begin
            hrs_inc = (hrs_q >= 5'd12) ? 5'd1 : hrs_q + 5'd1;
            hrs_dec = (hrs_q <= 5'd1 || hrs_q > 5'd12) ? 5'd12 : hrs_q - 5'd1;
        end else begin
            hrs_inc = (hrs_q >= 5'd23) ? 5'd0 : hrs_q + 5'd1;
            hrs_dec = (hrs_q == 5'd0 || hrs_q > 5'd23) ? 5'd23 : hrs_q - 5'd1;
        end
        min_inc = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
        min_dec = (min_q == 6'd0 || min_q > 6'd59) ? 6'd59 : min_q - 6'd1;
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        hrs_d   = hrs_q;
        am_d    = am_q;
        pm_d    = pm_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (mode_ev) begin
                    state_d = EDIT_HRS;
                    hrs_d   = load_hrs;
                    min_d   = load_min;
                    am_d    = load_am;
                    pm_d    = load_pm;
                end
            end
            EDIT_HRS, EDIT_MIN, EDIT_AMPM: begin
                to_d = any_ev ? '0 : to_q + 1'b1;
                if (sw_chg) begin
                    state_d = IDLE;
                end else if (mode_ev) begin
                    case (state_q)
                        EDIT_HRS: state_d = EDIT_MIN;
                        EDIT_MIN: state_d = switch ? EDIT_AMPM : COMMIT;
                        default:  state_d = COMMIT;
                    endcase
                end else if (step_inc || step_dec) begin
                    case (state_q)
                        EDIT_HRS: hrs_d = step_inc ? hrs_inc : hrs_dec;
                        EDIT_MIN: min_d = step_inc ? min_inc : min_dec;
                        default: begin
                            am_d = ~am_q;
                            pm_d = ~pm_q;
                        end
                    endcase
                end else if (!any_ev && to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            press_q   <= '0;
            rep_arm_q <= '0;
            rep_ev_q  <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
            state_q   <= IDLE;
            min_q     <= 6'd0;
            hrs_q     <= 5'd1;
            am_q      <= 1'b1;
            pm_q      <= 1'b0;
            to_q      <= '0;
            sw_q      <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            rep_arm_q <= rep_arm_d;
            rep_ev_q  <= rep_ev_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
            state_q   <= state_d;
            min_q     <= min_d;
            hrs_q     <= hrs_d;
            am_q      <= am_d;
            pm_q      <= pm_d;
            to_q      <= to_d;
            sw_q      <= switch;
        end
    end

    assign setMin  = min_q;
    assign setHrs  = hrs_q;
    assign setAM   = am_q;
    assign setPM   = pm_q;
    assign setTime = (state_q == COMMIT);
    assign editing = (state_q == EDIT_HRS) || (state_q == EDIT_MIN) || (state_q == EDIT_AMPM);

    always_comb begin
        case (state_q)
            EDIT_HRS:  edit_field = 2'd1;
            EDIT_MIN:  edit_field = 2'd2;
            EDIT_AMPM: edit_field = 2'd3;
            default:   edit_field = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - scoreboard bench for time_set_controller
`timescale 1ns/1ps
module tb_time_set_controller;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 2;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic       sw = 1'b0;
    logic [5:0] cur_min = '0;
    logic [4:0] cur_hrs = '0;
    logic       cur_pm = 1'b0;
    logic [5:0] setMin;
    logic [4:0] setHrs;
    logic       setAM, setPM, setTime, editing;
    logic [1:0] edit_field;

    time_set_controller #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .switch(sw), .cur_min(cur_min), .cur_hrs(cur_hrs), .cur_pm(cur_pm),
        .setMin(setMin), .setHrs(setHrs), .setAM(setAM), .setPM(setPM),
        .setTime(setTime), .editing(editing), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hrs; int min; int am; int pm; int editing; int field; int pulses;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int m_hrs = 1, m_min = 0, m_am = 1, m_pm = 0, m_field = 0, m_pulses = 0;

    always @(negedge clk) if (setTime === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.hrs = m_hrs; e.min = m_min; e.am = m_am; e.pm = m_pm;
        e.editing = (m_field != 0) ? 1 : 0;
        e.field = m_field; e.pulses = m_pulses;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".setHrs"},     setHrs,     e.hrs);
        chk({tag, ".setMin"},     setMin,     e.min);
        chk({tag, ".setAM"},      setAM,      e.am);
        chk({tag, ".setPM"},      setPM,      e.pm);
        chk({tag, ".editing"},    editing,    e.editing);
        chk({tag, ".edit_field"}, edit_field, e.field);
        chk({tag, ".setTime_n"},  pulses,     e.pulses);
    endtask

    function automatic int n_events(input int hold);
        int n;
        if (hold < DB) return 0;
        n = 1;
        for (int t = RD; t <= hold - 1; t += RR) n++;
        return n;
    endfunction

    task automatic m_mode();
        case (m_field)
            0: begin
                m_min = (cur_min > 59) ? 0 : int'(cur_min);
                if (sw) begin
                    if (cur_hrs == 0) begin
                        m_hrs = 12; m_am = 1; m_pm = 0;
                    end else if (cur_hrs > 12) begin
                        m_hrs = int'(cur_hrs) - 12; m_am = 0; m_pm = 1;
                    end else begin
                        m_hrs = int'(cur_hrs); m_am = cur_pm ? 0 : 1; m_pm = cur_pm ? 1 : 0;
                    end
                end else begin
                    m_hrs = (cur_hrs > 23) ? 0 : int'(cur_hrs); m_am = 0; m_pm = 0;
                end
                m_field = 1;
            end
            1: m_field = 2;
            2: if (sw) m_field = 3; else begin m_field = 0; m_pulses++; end
            default: begin m_field = 0; m_pulses++; end
        endcase
    endtask

    task automatic m_step(input int dir);
        case (m_field)
            1: if (sw) m_hrs = (dir > 0) ? (m_hrs % 12) + 1 : ((m_hrs + 10) % 12) + 1;
               else    m_hrs = (m_hrs + dir + 24) % 24;
            2: m_min = (m_min + dir + 60) % 60;
            3: begin m_am = 1 - m_am; m_pm = 1 - m_pm; end
            default: ;
        endcase
    endtask

    task automatic press(input string tag, input bit m, input bit i, input bit d, input int hold);
        int n;
        n = n_events(hold);
        if (m) begin
            if (n > 0) m_mode();
        end else if (i && !d) begin
            repeat (n) m_step(1);
        end else if (d && !i) begin
            repeat (n) m_step(-1);
        end
        push_exp();
        @(posedge clk); #1;
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (DB + 8) @(posedge clk);
        @(negedge clk);
        pop_check(tag);
    endtask

    task automatic model_reset();
        m_hrs = 1; m_min = 0; m_am = 1; m_pm = 0; m_field = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_exp();
        pop_check("reset");
        chk("reset.setTime", setTime, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Debounce boundary, then 24h full edit
        sw = 1'b0; cur_hrs = 5'd23; cur_min = 6'd58; cur_pm = 1'b0;
        press("glitch", 1, 0, 0, DB - 1);
        press("mode24", 1, 0, 0, DB);
        press("hrs_inc", 0, 1, 0, 6);
        press("to_min", 1, 0, 0, 6);
        press("min_inc1", 0, 1, 0, 6);
        press("min_inc2", 0, 1, 0, 6);
        press("commit24", 1, 0, 0, 6);

        // 12h edit including AM/PM
        sw = 1'b1; cur_hrs = 5'd12; cur_min = 6'd0; cur_pm = 1'b0;
        press("mode12", 1, 0, 0, 6);
        press("hrs12_inc", 0, 1, 0, 6);
        press("to_min12", 1, 0, 0, 6);
        press("min_dec", 0, 0, 1, 6);
        press("to_ampm", 1, 0, 0, 6);
        press("ampm_inc", 0, 1, 0, 6);
        press("commit12", 1, 0, 0, 6);

        // 12h conversion of 15, then timeout abort
        cur_hrs = 5'd15; cur_pm = 1'b1;
        press("load15", 1, 0, 0, 6);
        repeat (20) @(posedge clk);
        @(negedge clk);
        push_exp();
        pop_check("pre_timeout");
        repeat (TO) @(posedge clk);
        @(negedge clk);
        m_field = 0;
        push_exp();
        pop_check("timeout");

        // 12h conversion of 0, then asynchronous reset mid-edit
        cur_hrs = 5'd0; cur_pm = 1'b0;
        press("load0", 1, 0, 0, 6);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp();
        pop_check("rst_mid");
        chk("rst_mid.setTime", setTime, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Auto-repeat, simultaneous events
        sw = 1'b0; cur_hrs = 5'd5; cur_min = 6'd0;
        press("mode_ar", 1, 0, 0, 6);
        press("to_min_ar", 1, 0, 0, 6);
        press("repeat", 0, 1, 0, RD + 3 * RR);
        press("inc_dec", 0, 1, 1, 6);
        press("mode_inc", 1, 1, 0, 6);

        // Switch change while editing
        press("mode_sw", 1, 0, 0, 6);
        press("to_min_sw", 1, 0, 0, 6);
        @(posedge clk); #1;
        sw = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_field = 0;
        push_exp();
        pop_check("sw_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
